// File: rtl/self_flow_pkg.sv
// rtl/self_flow_pkg.sv - shared types and constant helpers for the SELF merge arbiter
package self_flow_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/self_flow_rr_picker.sv
// rtl/self_flow_rr_picker.sv - combinational round-robin search from a rotating start index
module self_flow_rr_picker
    import self_flow_pkg::*;
#(
    parameter int NumPorts = 2,
    localparam int IdW = clog2(NumPorts)
) (
    input  logic [NumPorts-1:0] i_req,
    input  logic [IdW-1:0]      i_rr_ptr,
    output logic [NumPorts-1:0] o_gnt,
    output logic [IdW-1:0]      o_idx,
    output logic                o_any
);

    // Walk the offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int k = NumPorts - 1; k >= 0; k--) begin
            if (i_req[(int'(i_rr_ptr) + k) % NumPorts]) begin
                o_gnt = '0;
                o_gnt[(int'(i_rr_ptr) + k) % NumPorts] = 1'b1;
                o_idx = IdW'((int'(i_rr_ptr) + k) % NumPorts);
                o_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/self_flow_merge_arbiter.sv
// rtl/self_flow_merge_arbiter.sv - N-to-1 SELF merge with burst locking and round-robin fairness
module self_flow_merge_arbiter
    import self_flow_pkg::*;
#(
    parameter int NumPorts  = 2,
    parameter int DataWidth = 32,
    localparam int IdW = clog2(NumPorts)
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic [NumPorts*DataWidth-1:0] dataIn,
    input  logic [NumPorts-1:0]           ctrlInReady,
    input  logic [NumPorts-1:0]           ctrlInLast,
    output logic [NumPorts-1:0]           ctrlInStop,
    output logic [DataWidth-1:0]          dataOut,
    output logic                          ctrlOutReady,
    output logic                          ctrlOutLast,
    input  logic                          ctrlOutStop,
    output logic [IdW-1:0]                grantId
);

    state_t               r_state;
    logic [IdW-1:0]       r_rr_ptr;
    logic [IdW-1:0]       r_lock_id;
    logic [DataWidth-1:0] r_data;
    logic                 r_last;
    logic [IdW-1:0]       r_grant;
    logic                 r_out_ready;

    logic                 w_free;
    logic [NumPorts-1:0]  w_pick_gnt;
    logic [IdW-1:0]       w_pick_idx;
    logic                 w_pick_any;
    logic [IdW-1:0]       w_sel_idx;
    logic                 w_sel_any;
    logic [NumPorts-1:0]  w_sel_onehot;
    logic                 w_accept;
    logic [IdW-1:0]       w_rr_next;

    self_flow_rr_picker #(.NumPorts(NumPorts)) u_picker (
        .i_req    (ctrlInReady),
        .i_rr_ptr (r_rr_ptr),
        .o_gnt    (w_pick_gnt),
        .o_idx    (w_pick_idx),
        .o_any    (w_pick_any)
    );

    assign w_free       = ~r_out_ready | ~ctrlOutStop;
    assign w_sel_idx    = (r_state == ST_LOCKED) ? r_lock_id : w_pick_idx;
    assign w_sel_any    = (r_state == ST_LOCKED) | w_pick_any;
    assign w_sel_onehot = (r_state == ST_LOCKED) ? (NumPorts'(1) << r_lock_id) : w_pick_gnt;
    assign w_accept     = w_free & w_sel_any & ctrlInReady[w_sel_idx];
    assign w_rr_next    = (w_sel_idx == IdW'(NumPorts - 1)) ? '0 : w_sel_idx + IdW'(1);

    // The owner sees stop=0 even while idle so it can resume its burst without a bubble.
    assign ctrlInStop = (nrst && w_free) ? ~w_sel_onehot : '1;

    assign dataOut      = r_data;
    assign ctrlOutReady = r_out_ready;
    assign ctrlOutLast  = r_last;
    assign grantId      = r_grant;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_lock_id   <= '0;
            r_data      <= '0;
            r_last      <= 1'b0;
            r_grant     <= '0;
            r_out_ready <= 1'b0;
        end else if (w_accept) begin
            r_data      <= dataIn[w_sel_idx*DataWidth +: DataWidth];
            r_last      <= ctrlInLast[w_sel_idx];
            r_grant     <= w_sel_idx;
            r_out_ready <= 1'b1;
            if (ctrlInLast[w_sel_idx]) begin
                r_state  <= ST_IDLE;
                r_rr_ptr <= w_rr_next;
            end else begin
                r_state   <= ST_LOCKED;
                r_lock_id <= w_sel_idx;
            end
        end else if (w_free) begin
            r_out_ready <= 1'b0;
        end
    end

endmodule

// File: tb/tb_self_flow_merge_arbiter.sv
// tb/tb_self_flow_merge_arbiter.sv - randomized scoreboard bench for self_flow_merge_arbiter
module tb_self_flow_merge_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            nrst = 1'b0;
    logic [N*DW-1:0] dataIn = '0;
    logic [N-1:0]    ctrlInReady = '0;
    logic [N-1:0]    ctrlInLast = '0;
    logic [N-1:0]    ctrlInStop;
    logic [DW-1:0]   dataOut;
    logic            ctrlOutReady;
    logic            ctrlOutLast;
    logic            ctrlOutStop = 1'b0;
    logic [1:0]      grantId;

    self_flow_merge_arbiter #(.NumPorts(N), .DataWidth(DW)) dut (
        .clk          (clk),
        .nrst         (nrst),
        .dataIn       (dataIn),
        .ctrlInReady  (ctrlInReady),
        .ctrlInLast   (ctrlInLast),
        .ctrlInStop   (ctrlInStop),
        .dataOut      (dataOut),
        .ctrlOutReady (ctrlOutReady),
        .ctrlOutLast  (ctrlOutLast),
        .ctrlOutStop  (ctrlOutStop),
        .grantId      (grantId)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
        int            p;
    } beat_t;

    beat_t exp_q[$];
    int    n_total = 0;
    int    n_bad = 0;
    bit    mon_en = 1'b0;

    // Reference model: burst owner (-1 = none), next priority port, output occupancy.
    int    m_owner = -1;
    int    m_rr = 0;
    bit    m_out_valid = 1'b0;

    logic [DW-1:0] s_d[N];
    logic          s_l[N];
    bit            s_r[N];

    bit  c_acc = 1'b0;
    bit  c_free = 1'b0;
    int  c_sel = 0;

    int  g_rdy_pct, g_last_pct, g_stop_pct;
    bit  g_toggle, g_all;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_sources();
        for (int p = 0; p < N; p++) begin
            dataIn[p*DW +: DW] = s_d[p];
            ctrlInReady[p]     = s_r[p];
            ctrlInLast[p]      = s_l[p];
        end
    endtask

    task automatic model_reset();
        m_owner     = -1;
        m_rr        = 0;
        m_out_valid = 1'b0;
        c_acc       = 1'b0;
        c_free      = 1'b0;
        for (int p = 0; p < N; p++) begin
            s_r[p] = 1'b0;
            s_l[p] = 1'b0;
            s_d[p] = '0;
        end
        exp_q.delete();
        drive_sources();
    endtask

    task automatic step();
        int           sel;
        bit           has;
        logic [N-1:0] exp_stop;
        @(posedge clk);
        if (c_acc) begin
            m_out_valid = 1'b1;
            s_r[c_sel]  = 1'b0;
            if (s_l[c_sel]) begin
                m_owner = -1;
                m_rr    = (c_sel + 1) % N;
            end else begin
                m_owner = c_sel;
            end
        end else if (c_free) begin
            m_out_valid = 1'b0;
        end
        #1;
        for (int p = 0; p < N; p++) begin
            if (!s_r[p] && (g_all || $urandom_range(99) < g_rdy_pct)) begin
                s_r[p] = 1'b1;
                s_d[p] = $urandom;
                s_l[p] = ($urandom_range(99) < g_last_pct);
            end
        end
        if (g_toggle) ctrlOutStop = ~ctrlOutStop;
        else          ctrlOutStop = ($urandom_range(99) < g_stop_pct);
        drive_sources();

        c_free = !m_out_valid || !ctrlOutStop;
        sel = 0;
        has = 1'b0;
        if (m_owner >= 0) begin
            sel = m_owner;
            has = 1'b1;
        end else begin
            for (int k = N - 1; k >= 0; k--) begin
                if (s_r[(m_rr + k) % N]) begin
                    sel = (m_rr + k) % N;
                    has = 1'b1;
                end
            end
        end
        exp_stop = '1;
        if (c_free && has) exp_stop[sel] = 1'b0;
        c_acc = c_free && has && s_r[sel];
        c_sel = sel;
        if (c_acc) exp_q.push_back('{d: s_d[sel], l: s_l[sel], p: sel});
        #1;
        check("in_stop", 64'(ctrlInStop), 64'(exp_stop));
    endtask

    task automatic run(input int cycles, input int rp, input int lp, input int sp,
                       input bit tog, input bit allr);
        g_rdy_pct  = rp;
        g_last_pct = lp;
        g_stop_pct = sp;
        g_toggle   = tog;
        g_all      = allr;
        repeat (cycles) step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_ready"}, 64'(ctrlOutReady), 64'd0);
        check({tag, "_out_last"},  64'(ctrlOutLast),  64'd0);
        check({tag, "_data"},      64'(dataOut),      64'd0);
        check({tag, "_grant"},     64'(grantId),      64'd0);
        check({tag, "_in_stop"},   64'(ctrlInStop),   64'hF);
    endtask

    // Monitor: compares each beat the DUT presents at the moment it leaves the output register.
    initial begin
        beat_t b;
        forever begin
            @(negedge clk);
            if (nrst && mon_en) begin
                check("out_ready", 64'(ctrlOutReady), 64'(m_out_valid));
                if (ctrlOutReady && !ctrlOutStop) begin
                    if (exp_q.size() == 0) begin
                        n_total++;
                        n_bad++;
                        $display("FAIL unexpected_beat actual=%0h expected=none at %0t", dataOut, $time);
                    end else begin
                        b = exp_q.pop_front();
                        check("data",  64'(dataOut),     64'(b.d));
                        check("last",  64'(ctrlOutLast), 64'(b.l));
                        check("grant", 64'(grantId),     64'(b.p));
                    end
                end
            end
        end
    end

    initial begin
        model_reset();
        ctrlInReady = '1;
        #3;
        check_reset_outputs("por");
        ctrlInReady = '0;
        @(negedge clk);
        #1 nrst = 1'b1;
        mon_en = 1'b1;

        run(8,   100, 100, 0,  1'b0, 1'b1);
        run(300, 50,  35,  30, 1'b0, 1'b0);
        run(3,   100, 100, 0,  1'b0, 1'b1);
        run(6,   100, 100, 100, 1'b0, 1'b1);
        run(4,   100, 100, 0,  1'b0, 1'b1);
        run(200, 100, 40,  0,  1'b1, 1'b1);
        run(200, 30,  20,  60, 1'b0, 1'b0);
        run(10,  0,   0,   0,  1'b0, 1'b0);
        run(3,   100, 0,   0,  1'b0, 1'b1);

        #1;
        nrst   = 1'b0;
        mon_en = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        model_reset();
        @(negedge clk);
        #1 nrst = 1'b1;
        mon_en = 1'b1;
        run(8,   100, 100, 0,  1'b0, 1'b1);
        run(200, 60,  30,  25, 1'b0, 1'b0);
        run(8,   0,   0,   0,  1'b0, 1'b0);

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
